// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Good bytes are queued; bad stop bits and full-FIFO drops raise one-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_uartRx,
  output logic [7:0] io_rxData,
  output logic       io_rxValid,
  input  logic       io_rxReady,
  output logic       io_frameErr,
  output logic       io_overflow
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITIDLE} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      arm_q, arm_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];

  logic            rxs_c, armed_c, bit_done_c, half_done_c;
  logic            push_c, pop_c, full_c, wr_en_c;

  assign rxs_c       = sync2_q;
  assign armed_c     = (arm_q == 2'd3);
  assign bit_done_c  = (timer_q == BIT_LAST);
  assign half_done_c = (timer_q == HALF_LAST);

  // The synchronizer preset to 1 by reset must not count as a genuine idle line.
  always_comb begin
    sync1_d = io_uartRx;
    sync2_d = sync1_q;
    arm_d   = arm_q;
    if (arm_q == 2'd2) arm_d = rxs_c ? 2'd3 : 2'd2;
    else if (arm_q != 2'd3) arm_d = arm_q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (armed_c && !rxs_c) state_d = START;
      START:    if (half_done_c) state_d = rxs_c ? IDLE : DATA;
      DATA:     if (bit_done_c && (idx_q == 3'd7)) state_d = STOP;
      STOP:     if (bit_done_c) state_d = rxs_c ? IDLE : WAITIDLE;
      WAITIDLE: if (rxs_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d     = timer_q + TW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE:  timer_d = '0;
      START: if (half_done_c) begin
        timer_d = '0;
        idx_d   = '0;
      end
      DATA: if (bit_done_c) begin
        timer_d        = '0;
        shift_d[idx_q] = rxs_c;
        idx_d          = idx_q + 3'd1;
      end
      STOP: if (bit_done_c) begin
        timer_d     = '0;
        push_c      = rxs_c;
        frame_err_d = !rxs_c;
      end
      default: timer_d = '0;
    endcase
  end

  // FIFO bookkeeping; the head byte is registered so it can be reset to zero.
  always_comb begin
    full_c     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_c      = valid_q && io_rxReady;
    wr_en_c    = push_c && (!full_c || pop_c);
    overflow_d = push_c && full_c && !pop_c;
    wptr_d     = wr_en_c ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop_c ? rptr_q + PW'(1) : rptr_q;
    valid_d    = (wptr_d != rptr_d);
    if (wr_en_c && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) data_d = shift_q;
    else data_d = mem_q[rptr_d[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      arm_q       <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      arm_q       <= arm_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (reset && wr_en_c) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  assign io_rxData   = data_q;
  assign io_rxValid  = valid_q;
  assign io_frameErr = frame_err_q;
  assign io_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=16, DEPTH=4).
// Frames are serialised by tasks; a monitor pops expected bytes on each handshake.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow;

  int errors = 0, checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int exp_fe = 0, exp_ov = 0, fe_seen = 0, ov_seen = 0;
  bit fe_prev = 0, ov_prev = 0;
  int ready_mode = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .io_uartRx(uart_rx),
    .io_rxData(rx_data), .io_rxValid(rx_valid), .io_rxReady(rx_ready),
    .io_frameErr(frame_err), .io_overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Consumer: low, high, or random per cycle.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pop scoreboard on each handshake, count and width-check pulses.
  always @(negedge clock) begin
    if (reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop: got %0h, expected no byte", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_data", 32'(rx_data), 32'(mon_exp));
        end
      end
      if (frame_err) fe_seen++;
      if (overflow) ov_seen++;
      if (frame_err && fe_prev) check("frame_err_width", 32'(2), 32'(1));
      if (overflow && ov_prev) check("overflow_width", 32'(2), 32'(1));
    end
    fe_prev = frame_err;
    ov_prev = overflow;
  end

  // Serialise one 8N1 frame; the model decides the outcome before the stop bit is sampled.
  task automatic send_frame(input logic [7:0] b, input bit good, input bit check_lat);
    uart_rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(CPB);
    end
    if (good) begin
      if (exp_q.size() >= DEPTH) exp_ov++;
      else exp_q.push_back(b);
    end else exp_fe++;
    uart_rx = good;
    if (check_lat) begin
      cyc(8);
      check("valid_before_stop_sample", 32'(rx_valid), 32'(0));
      cyc(6);
      check("valid_after_stop_sample", 32'(rx_valid), 32'(1));
      check("head_data", 32'(rx_data), 32'(b));
      cyc(CPB - 14);
    end else cyc(CPB);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err_pulses"}, 32'(fe_seen), 32'(exp_fe));
    check({tag, "_overflow_pulses"}, 32'(ov_seen), 32'(exp_ov));
  endtask

  initial begin
    logic [7:0] rb;
    bit         rg;

    cyc(3);
    check("reset_valid", 32'(rx_valid), 32'(0));
    check("reset_data", 32'(rx_data), 32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_overflow", 32'(overflow), 32'(0));
    reset = 1'b1;
    cyc(2 * CPB);

    // Single byte held in FIFO with consumer stalled.
    send_frame(8'hA5, 1'b1, 1'b1);
    cyc(CPB);
    check("a5_held_valid", 32'(rx_valid), 32'(1));
    check("a5_held_data", 32'(rx_data), 32'hA5);
    check_counts("a5");

    // Drain, then three back-to-back frames with consumer ready.
    ready_mode = 1;
    cyc(4);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    uart_rx = 1'b1;
    cyc(2 * CPB);
    check("b2b_drained", 32'(exp_q.size()), 32'(0));
    check("b2b_empty", 32'(rx_valid), 32'(0));

    // Short low glitch must not start a frame.
    uart_rx = 1'b0;
    cyc(4);
    uart_rx = 1'b1;
    cyc(3 * CPB);
    check("glitch_valid", 32'(rx_valid), 32'(0));
    check_counts("glitch");

    // Bad stop bit, line held low, then a good frame.
    send_frame(8'h55, 1'b0, 1'b0);
    uart_rx = 1'b0;
    cyc(40);
    uart_rx = 1'b1;
    cyc(2 * CPB);
    send_frame(8'h12, 1'b1, 1'b0);
    uart_rx = 1'b1;
    cyc(2 * CPB);
    check("ferr_drained", 32'(exp_q.size()), 32'(0));
    check_counts("ferr");

    // Overfill a stalled FIFO, then drain it.
    ready_mode = 0;
    cyc(2);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    uart_rx = 1'b1;
    cyc(2 * CPB);
    check("full_valid", 32'(rx_valid), 32'(1));
    check("full_head", 32'(rx_data), 32'h01);
    check_counts("overflow");
    ready_mode = 1;
    cyc(20);
    check("overflow_drained", 32'(exp_q.size()), 32'(0));
    check("overflow_empty", 32'(rx_valid), 32'(0));

    // Reset during data bit 3 of 0x77 aborts it; 0x99 follows.
    uart_rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = (8'h77 >> i) & 8'h01;
      cyc(CPB);
    end
    uart_rx = 1'b0;
    cyc(5);
    reset = 1'b0;
    cyc(2);
    check("midreset_valid", 32'(rx_valid), 32'(0));
    check("midreset_data", 32'(rx_data), 32'(0));
    reset = 1'b1;
    cyc(3);
    uart_rx = 1'b1;
    cyc(2 * CPB);
    send_frame(8'h99, 1'b1, 1'b0);
    uart_rx = 1'b1;
    cyc(2 * CPB);
    check("midreset_drained", 32'(exp_q.size()), 32'(0));
    check_counts("midreset");

    // Random frames with random stop-bit errors and a random consumer.
    ready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rg = ($urandom_range(0, 5) != 0);
      send_frame(rb, rg, 1'b0);
      if (!rg) begin
        uart_rx = 1'b0;
        cyc($urandom_range(0, 30));
        uart_rx = 1'b1;
        cyc($urandom_range(4, 2 * CPB));
      end else begin
        uart_rx = 1'b1;
        cyc($urandom_range(0, CPB));
      end
    end
    ready_mode = 1;
    uart_rx = 1'b1;
    cyc(2 * CPB);
    check("random_drained", 32'(exp_q.size()), 32'(0));
    check("random_empty", 32'(rx_valid), 32'(0));
    check_counts("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter DEPTH, default 8: receive FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset (reset=0 resets on the next rising clock edge).
REQ-005 SHALL have port io_uartRx  input  1: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port io_rxData  output  8: byte at the FIFO head.
REQ-007 SHALL have port io_rxValid  output  1: FIFO non-empty; io_rxData is valid.
REQ-008 SHALL have port io_rxReady  input  1: consumer accepts the head byte when high together with io_rxValid.
REQ-009 SHALL have port io_frameErr  output  1: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port io_overflow  output  1: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-011 SHALL pass io_uartRx through a 2-flop synchronizer; both flops reset to 1. Only the synchronized value (rxs) is used.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, WAITIDLE. Bit-timer width = clog2(CLKS_PER_BIT). Bit index is 3 bits.
REQ-013 IDLE: on rxs=0, SHALL clear the timer and enter START.
REQ-014 START: after (CLKS_PER_BIT/2)-1 further cycles, SHALL sample rxs. If 0, clear the timer, clear the bit index and enter DATA. If 1, treat as a glitch and return to IDLE with no output.
REQ-015 DATA: every CLKS_PER_BIT cycles, SHALL sample rxs into shift-register bit [index] (LSB first). After bit 7, enter STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, SHALL sample rxs.
  - Sample = 1: push the byte to the FIFO and enter IDLE.
  - Sample = 0: pulse io_frameErr, discard the byte and enter WAITIDLE.
REQ-017 WAITIDLE: SHALL remain until rxs=1 (break or line low), then enter IDLE; no start detection occurs in this state.
REQ-018 The FIFO SHALL be first-word-fall-through. A pushed byte appears on io_rxData with io_rxValid=1 on the cycle after the stop-bit sample edge when the FIFO was empty.
REQ-019 Pop SHALL occur when io_rxValid && io_rxReady. The head advances on that edge.
REQ-020 Push into a full FIFO without a simultaneous pop SHALL drop the new byte, pulse io_overflow, and leave contents unchanged.
REQ-021 Simultaneous push and pop when full SHALL accept both; the count is unchanged and io_overflow=0.
REQ-022 Simultaneous push and pop when empty SHALL not occur, since io_rxValid=0. The push takes effect normally.
REQ-023 Read/write pointers SHALL be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is asserted when the MSBs differ and the LSBs are equal.
REQ-024 io_rxData SHALL be don't-care while io_rxValid=0. io_rxValid SHALL not depend combinationally on io_rxReady.
REQ-025 io_frameErr and io_overflow SHALL be registered and high for exactly one cycle per event.

Reset
REQ-026 While reset=0, the following SHALL take effect on the next edge:
  - FSM = IDLE
  - timer, bit index and shift register = 0
  - synchronizer = 1
  - FIFO pointers = 0
  - io_rxValid = 0, io_frameErr = 0, io_overflow = 0
  - io_rxData = 0
REQ-027 Reset asserted mid-frame SHALL abort the frame with no push and no error pulse. After release, the next start bit SHALL be detected only after rxs has been seen high then low.
REQ-028 FIFO contents need not be cleared by reset; only pointers and flags are cleared.

Verification (CLKS_PER_BIT=16, DEPTH=4)
REQ-029 Send 0xA5 with io_rxReady=0 -> io_rxValid=1 and io_rxData=0xA5 one cycle after stop sample; no error pulses.
REQ-030 Send 0x3C, 0x81, 0xFF back-to-back with io_rxReady=1 -> three one-cycle handshakes in order 0x3C, 0x81, 0xFF; FIFO empty afterwards.
REQ-031 Drive a low glitch of 4 cycles on io_uartRx -> FSM returns to IDLE; no push, no pulses.
REQ-032 Send 0x55 with stop bit 0, then hold the line low 40 cycles, then send 0x12 -> io_frameErr pulses once; only 0x12 is received.
REQ-033 Send 5 bytes 0x01..0x05 with io_rxReady=0 -> first 4 stored; io_overflow pulses once on the 5th. Raise io_rxReady -> read order 0x01..0x04.
REQ-034 Assert reset for 2 cycles during data bit 3 of 0x77, then send 0x99 -> only 0x99 is received; no error pulses.
